// File: rtl/ripple_adder_pkg.sv
// rtl/ripple_adder_pkg.sv - shared constants for the ripple-carry adder slice
package ripple_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned MAX_WIDTH     = 64;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit full adder, one stage of the ripple chain
module full_adder_cell
   import ripple_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_8b.sv
// rtl/ripple_carry_adder_8b.sv - registered unsigned ripple-carry adder, {Cout,Sum} = A+B+Cin
module ripple_carry_adder_8b
   import ripple_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;

   // Each stage owns its carry-in/carry-out nets so the chain is a plain
   // sequence of separate signals rather than a self-feeding vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic c_in;
      logic c_out;

      if (i == 0) begin : g_first
         assign c_in = Cin;
      end else begin : g_rest
         assign c_in = g_bit[i-1].c_out;
      end

      full_adder_cell u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (c_in),
         .s    (s[i]),
         .cout (c_out)
      );
   end

   assign sum_d  = s;
   assign cout_d = g_bit[WIDTH-1].c_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_ripple_carry_adder_8b.sv
// tb/tb_ripple_carry_adder_8b.sv - directed and back-to-back checks of the registered adder at widths 8, 1 and 16
module tb_ripple_carry_adder_8b;

   logic        clk;
   logic        rst_n;
   logic [7:0]  a8, b8, sum8;
   logic        cin8, cout8;
   logic [0:0]  a1, b1, sum1;
   logic        cin1, cout1;
   logic [15:0] a16, b16, sum16;
   logic        cin16, cout16;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs [12];

   ripple_carry_adder_8b dut (
      .clk (clk), .rst_n (rst_n), .A (a8), .B (b8), .Cin (cin8), .Sum (sum8), .Cout (cout8)
   );

   ripple_carry_adder_8b #(.WIDTH(1)) u_w1 (
      .clk (clk), .rst_n (rst_n), .A (a1), .B (b1), .Cin (cin1), .Sum (sum1), .Cout (cout1)
   );

   ripple_carry_adder_8b #(.WIDTH(16)) u_w16 (
      .clk (clk), .rst_n (rst_n), .A (a16), .B (b16), .Cin (cin16), .Sum (sum16), .Cout (cout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic ec);
      @(negedge clk);
      a8 = a; b8 = b; cin8 = ci;
      @(posedge clk);
      #1;
      check($sformatf("%s_sum", tag), 64'(sum8), 64'(es));
      check($sformatf("%s_cout", tag), 64'(cout8), 64'(ec));
   endtask

   task automatic check_all_zero(input string tag);
      check($sformatf("%s_w8", tag), 64'({cout8, sum8}), 64'd0);
      check($sformatf("%s_w1", tag), 64'({cout1, sum1}), 64'd0);
      check($sformatf("%s_w16", tag), 64'({cout16, sum16}), 64'd0);
   endtask

   initial begin
      logic [8:0]  e9;
      logic [1:0]  e2;
      logic [16:0] e17;

      n_checks = 0;
      n_errors = 0;

      vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
      vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[4]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
      vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
      vecs[7]  = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
      vecs[8]  = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};
      vecs[9]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
      vecs[10] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
      vecs[11] = '{8'h04, 8'h04, 1'b0, 8'h08, 1'b0};

      rst_n = 1'b1;
      a8  = 8'hFF;    b8  = 8'hFF;    cin8  = 1'b1;
      a1  = 1'b1;     b1  = 1'b1;     cin1  = 1'b1;
      a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;

      #3 rst_n = 1'b0;
      #1;
      check_all_zero("reset_async");
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_hold");

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         apply8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
      end

      apply8("pre_reset", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid");
      @(posedge clk);
      #1;
      check_all_zero("reset_mid_edge");
      @(negedge clk);
      rst_n = 1'b1;
      apply8("first_capture", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a1 = i[0]; b1 = i[1]; cin1 = i[2];
         e2 = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
         @(posedge clk);
         #1;
         check($sformatf("w1_exh%0d", i), 64'({cout1, sum1}), 64'(e2));
      end

      @(negedge clk);
      a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
      @(posedge clk);
      #1;
      check("w16_wrap", 64'({cout16, sum16}), 64'h10000);

      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
         a1  = 1'($urandom);  b1  = 1'($urandom);  cin1  = 1'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
         e9  = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
         e2  = {1'b0, a1} + {1'b0, b1} + 2'(cin1);
         e17 = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
         @(posedge clk);
         #1;
         check($sformatf("rand%0d_w8", k), 64'({cout8, sum8}), 64'(e9));
         check($sformatf("rand%0d_w1", k), 64'({cout1, sum1}), 64'(e2));
         check($sformatf("rand%0d_w16", k), 64'({cout16, sum16}), 64'(e17));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ripple_carry_adder_8b.md
Name: ripple_carry_adder_8b

Overview:
- Unsigned 8-bit ripple-carry adder: Sum/Cout = A + B + Cin, built as a chain of full-adder cells.
- Result is captured in an output register: one clock of latency, asynchronous active-low reset.
- Datapath arithmetic leaf used wherever a small registered adder is needed.
- Width is parameterised; default 8.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..64).

Ports:
- clk    input   1      single clock; all state updates on rising edge
- rst_n  input   1      asynchronous reset, active low
- A      input   WIDTH  operand A, unsigned
- B      input   WIDTH  operand B, unsigned
- Cin    input   1      carry into bit 0
- Sum    output  WIDTH  registered low WIDTH bits of A+B+Cin
- Cout   output  1      registered carry out of bit WIDTH-1

Behaviour:
- Interface rule (already decided): one clock; reset is asynchronous and active-low.
- Arithmetic: {Cout, Sum} = A + B + Cin, evaluated at full WIDTH+1 bits. No truncation before the final carry. No signed interpretation and no overflow flag.
- Structure: WIDTH full-adder cells. Cell i takes A[i], B[i] and c[i], where c[0] = Cin. Cell i produces s[i] = A[i]^B[i]^c[i] and c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i])). No carry-lookahead; the carry chain is a pure ripple.
- Registering: on each rising clk with rst_n high, Sum <= s[WIDTH-1:0] and Cout <= c[WIDTH].
- Latency is exactly 1 cycle. Inputs changed before edge k appear on outputs after edge k. There is no enable, so every cycle loads.
- Reset: when rst_n falls, Sum = 0 and Cout = 0 immediately, without waiting for a clock edge. Outputs hold 0 while rst_n is low.
  - The first capture happens on the first rising clk after rst_n deasserts.
  - Reset deassertion is synchronised externally; the block does not resynchronise it.
- Reset asserted mid-operation: any in-flight result is discarded and outputs go to 0 at once.
- Timing budget: the combinational ripple path from A/B/Cin to register D must close within one clk period. At 8 bits this targets 100 MHz.
- No X propagation is allowed from reset state. Outputs never show X after reset.
- Boundary results:
  - FF+FF+0 gives Sum=FE, Cout=1.
  - FF+FF+1 gives Sum=FF, Cout=1.
  - FF+01 gives Sum=00, Cout=1 (full wrap).
  - 00+00+0 gives Sum=00, Cout=0.

Decomposition:
- Shared package ripple_adder_pkg: localparam DEFAULT_WIDTH = 8.
- One sub-module, full_adder_cell, with inputs a, b, cin and outputs s, cout. It is instantiated WIDTH times via a generate loop.
- The top level holds the carry vector c[WIDTH:0] and the output register.

Test Plan (apply inputs, release reset, check outputs one clk later against a WIDTH+1-bit model):
- Reset check: hold rst_n=0 with A=FF, B=FF, Cin=1 -> Sum=00, Cout=0. Assert rst_n low mid-run -> outputs go to 0 before the next edge.
- Extremes:
  - A=00, B=00, Cin=0 -> Sum=00, Cout=0.
  - A=FF, B=FF, Cin=0 -> Sum=FE, Cout=1.
  - A=FF, B=FF, Cin=1 -> Sum=FF, Cout=1.
- Full carry ripple:
  - A=FF, B=01, Cin=0 -> Sum=00, Cout=1.
  - A=00, B=FF, Cin=1 -> Sum=00, Cout=1.
  - A=80, B=80, Cin=0 -> Sum=00, Cout=1.
- Patterns:
  - A=AA, B=55, Cin=0 -> Sum=FF, Cout=0.
  - A=55, B=AA, Cin=1 -> Sum=00, Cout=1.
  - A=3C, B=C3, Cin=0 -> Sum=FF, Cout=0.
  - A=7F, B=7F, Cin=1 -> Sum=FF, Cout=0.
  - A=01, B=01, Cin=1 -> Sum=03, Cout=0.
  - A=04, B=04, Cin=0 -> Sum=08, Cout=0.
- Latency and back-to-back: change inputs every cycle over 1000 random vectors -> outputs at cycle k+1 match the model for inputs at cycle k. No pipeline bubbles.
- Parameter sweep: WIDTH=1 and WIDTH=16 with exhaustive or random vectors -> {Cout, Sum} equals A+B+Cin.
